// File: rtl/trail_stack_pkg.sv
// Shared types and constants for the DPLL assignment-trail stack.
// Entry encoding is {var, val, type}; type distinguishes decisions from implications.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

package trail_pkg;

  localparam int MAX_VARS_BITS = `MAX_VARS_BITS;

  localparam logic TYPE_DECIDE = 1'b0;
  localparam logic TYPE_FORCED = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    UNWIND = 1'b1
  } trail_state_t;

  function automatic logic is_decision(input logic typ);
    return typ == TYPE_DECIDE;
  endfunction

endpackage

// File: rtl/trail_stack_if.sv
// Command/status bundle between the decision/BCP units (master) and the trail stack (slave).
interface trail_stack_if #(
  parameter int VAR_BITS = trail_pkg::MAX_VARS_BITS,
  parameter int CNT_BITS = 5
);

  logic                push;
  logic                pop;
  logic                backtrack;
  logic                type_in;
  logic                val_in;
  logic [VAR_BITS-1:0] var_in;

  logic [VAR_BITS-1:0] var_out;
  logic                val_out;
  logic                type_out;

  logic                unassign_valid;
  logic [VAR_BITS-1:0] unassign_var;
  logic                flip_valid;
  logic [VAR_BITS-1:0] flip_var;
  logic                flip_val;

  logic                busy;
  logic                unsat;
  logic                error;
  logic [CNT_BITS-1:0] count;
  logic [CNT_BITS-1:0] level;
  logic                empty;
  logic                full;

  modport master (
    output push, pop, backtrack, type_in, val_in, var_in,
    input  var_out, val_out, type_out,
    input  unassign_valid, unassign_var, flip_valid, flip_var, flip_val,
    input  busy, unsat, error, count, level, empty, full
  );

  modport slave (
    input  push, pop, backtrack, type_in, val_in, var_in,
    output var_out, val_out, type_out,
    output unassign_valid, unassign_var, flip_valid, flip_var, flip_val,
    output busy, unsat, error, count, level, empty, full
  );

endinterface

// File: rtl/trail_stack_mem.sv
// Trail entry storage: one write port, one combinational read port, no reset.
// Out-of-range indices read as zero and never write.
module trail_mem #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 10,
  parameter int IDX_BITS = 5
) (
  input  logic                clock,
  input  logic                i_we,
  input  logic [IDX_BITS-1:0] i_wr_idx,
  input  logic [WIDTH-1:0]    i_wr_data,
  input  logic [IDX_BITS-1:0] i_rd_idx,
  output logic [WIDTH-1:0]    o_rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_BITS-1:0] LIMIT = IDX_BITS'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_ok;
  logic             w_rd_ok;

  assign w_wr_ok = i_we && (i_wr_idx < LIMIT);
  assign w_rd_ok = i_rd_idx < LIMIT;

  always_ff @(posedge clock) begin
    if (w_wr_ok) begin
      r_mem[i_wr_idx[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_rd_data = w_rd_ok ? r_mem[i_rd_idx[AW-1:0]] : '0;

endmodule

// File: rtl/trail_stack.sv
// Assignment-trail stack with push/pop and a backtrack sequencer that unwinds
// forced entries down to the newest decision, flips it, or flags unsat.
//
// state  | meaning
// IDLE   | accepts push/pop/backtrack
// UNWIND | one top entry per cycle: forced -> unassign+pop, decision -> flip+exit
module trail_stack
  import trail_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int VAR_BITS = MAX_VARS_BITS,
  parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  trail_stack_if.slave  bus
);

  localparam int                  WIDTH    = VAR_BITS + 2;
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] ONE      = CNT_BITS'(1);

  trail_state_t        r_state;
  logic [CNT_BITS-1:0] r_count;
  logic [CNT_BITS-1:0] r_level;
  logic                r_unsat;
  logic                r_error;

  logic                w_empty;
  logic                w_full;
  logic                w_unwind;
  logic [CNT_BITS-1:0] w_top_idx;
  logic [WIDTH-1:0]    w_top;
  logic [VAR_BITS-1:0] w_top_var;
  logic                w_top_val;
  logic                w_top_type;
  logic [CNT_BITS-1:0] w_dec_in;
  logic [CNT_BITS-1:0] w_dec_top;
  logic                w_idle_cmd;
  logic                w_push;
  logic                w_swap;
  logic                w_flip;
  logic                w_we;
  logic [CNT_BITS-1:0] w_wr_idx;
  logic [WIDTH-1:0]    w_wr_data;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_unwind  = (r_state == UNWIND);
  assign w_top_idx = r_count - ONE;

  assign w_top_var  = w_top[WIDTH-1:2];
  assign w_top_val  = w_top[1];
  assign w_top_type = w_top[0];

  assign w_dec_in  = CNT_BITS'(is_decision(bus.type_in));
  assign w_dec_top = CNT_BITS'(is_decision(w_top_type));

  // Backtrack outranks push/pop in IDLE; a push+pop on an empty stack is a plain push.
  assign w_idle_cmd = !w_unwind && !bus.backtrack;
  assign w_push     = w_idle_cmd && bus.push && (!bus.pop || w_empty) && !w_full;
  assign w_swap     = w_idle_cmd && bus.push && bus.pop && !w_empty;
  assign w_flip     = w_unwind && (w_top_type == TYPE_DECIDE);

  assign w_we      = w_push || w_swap || w_flip;
  assign w_wr_idx  = w_push ? r_count : w_top_idx;
  assign w_wr_data = w_flip ? {w_top_var, ~w_top_val, TYPE_FORCED}
                            : {bus.var_in, bus.val_in, bus.type_in};

  trail_mem #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .IDX_BITS (CNT_BITS)
  ) u_mem (
    .clock     (clock),
    .i_we      (w_we),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (w_wr_data),
    .i_rd_idx  (w_top_idx),
    .o_rd_data (w_top)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_level <= '0;
      r_unsat <= 1'b0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.backtrack) begin
            if (w_empty) begin
              r_unsat <= 1'b1;
            end else begin
              r_state <= UNWIND;
            end
          end else if (bus.push && bus.pop) begin
            if (w_empty) begin
              r_count <= ONE;
              r_level <= r_level + w_dec_in;
            end else begin
              r_level <= r_level - w_dec_top + w_dec_in;
            end
          end else if (bus.push) begin
            if (w_full) begin
              r_error <= 1'b1;
            end else begin
              r_count <= r_count + ONE;
              r_level <= r_level + w_dec_in;
            end
          end else if (bus.pop) begin
            if (w_empty) begin
              r_error <= 1'b1;
            end else begin
              r_count <= w_top_idx;
              r_level <= r_level - w_dec_top;
            end
          end
        end
        UNWIND: begin
          if (bus.push || bus.pop) begin
            r_error <= 1'b1;
          end
          if (w_top_type == TYPE_FORCED) begin
            r_count <= w_top_idx;
            if (r_count == ONE) begin
              r_unsat <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_level <= r_level - ONE;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.var_out  = w_empty ? '0 : w_top_var;
  assign bus.val_out  = !w_empty && w_top_val;
  assign bus.type_out = !w_empty && w_top_type;

  assign bus.unassign_valid = w_unwind && (w_top_type == TYPE_FORCED);
  assign bus.unassign_var   = bus.unassign_valid ? w_top_var : '0;
  assign bus.flip_valid     = w_flip;
  assign bus.flip_var       = w_flip ? w_top_var : '0;
  assign bus.flip_val       = w_flip && !w_top_val;

  assign bus.busy  = w_unwind;
  assign bus.unsat = r_unsat;
  assign bus.error = r_error;
  assign bus.count = r_count;
  assign bus.level = r_level;
  assign bus.empty = w_empty;
  assign bus.full  = w_full;

  // The sequencer never runs on an empty stack, and decisions are a subset of entries.
  a_level_le_count: assert property (@(posedge clock) disable iff (!reset_n) r_level <= r_count);
  a_unwind_nonempty: assert property (@(posedge clock) disable iff (!reset_n) !(w_unwind && w_empty));

endmodule

// File: tb/tb_trail_stack.sv
// Randomized and directed stimulus for trail_stack, checked against a queue-based model.
module tb_trail_stack;
  import trail_pkg::*;

  localparam int DEPTH = 4;
  localparam int VB    = 8;
  localparam int CB    = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  trail_stack_if #(.VAR_BITS(VB), .CNT_BITS(CB)) bus ();

  trail_stack #(.DEPTH(DEPTH), .VAR_BITS(VB), .CNT_BITS(CB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [VB-1:0] v;
    logic          val;
    logic          typ;
  } ent_t;

  typedef struct {
    logic          is_flip;
    logic [VB-1:0] v;
    logic          val;
  } pulse_t;

  ent_t   m_stack[$];
  pulse_t m_pulses[$];
  logic   m_busy, m_unsat, m_error;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string ctx);
    ent_t   top;
    pulse_t p;
    int     lvl;
    int     n;
    top = '{default: '0};
    p   = '{default: '0};
    lvl = 0;
    n   = m_stack.size();
    if (n > 0) top = m_stack[n-1];
    foreach (m_stack[i]) if (m_stack[i].typ == TYPE_DECIDE) lvl++;
    if (m_busy && m_pulses.size() > 0) p = m_pulses[0];
    check_eq({ctx, ".count"},  32'(bus.count), 32'(n));
    check_eq({ctx, ".level"},  32'(bus.level), 32'(lvl));
    check_eq({ctx, ".empty"},  32'(bus.empty), 32'(n == 0));
    check_eq({ctx, ".full"},   32'(bus.full),  32'(n == DEPTH));
    check_eq({ctx, ".var_out"},  32'(bus.var_out),  32'(top.v));
    check_eq({ctx, ".val_out"},  32'(bus.val_out),  32'(top.val));
    check_eq({ctx, ".type_out"}, 32'(bus.type_out), 32'(top.typ));
    check_eq({ctx, ".busy"},   32'(bus.busy),  32'(m_busy));
    check_eq({ctx, ".unsat"},  32'(bus.unsat), 32'(m_unsat));
    check_eq({ctx, ".error"},  32'(bus.error), 32'(m_error));
    check_eq({ctx, ".unassign_valid"}, 32'(bus.unassign_valid), 32'(m_busy && !p.is_flip));
    check_eq({ctx, ".unassign_var"},   32'(bus.unassign_var),   (m_busy && !p.is_flip) ? 32'(p.v) : 32'd0);
    check_eq({ctx, ".flip_valid"},     32'(bus.flip_valid),     32'(m_busy && p.is_flip));
    check_eq({ctx, ".flip_var"},       32'(bus.flip_var),       (m_busy && p.is_flip) ? 32'(p.v) : 32'd0);
    check_eq({ctx, ".flip_val"},       32'(bus.flip_val),       32'(m_busy && p.is_flip && p.val));
  endtask

  // Backtrack is modelled as a precomputed pulse list read from the stack snapshot.
  task automatic model_update(input logic p, input logic po, input logic bt,
                              input logic t, input logic vl, input logic [VB-1:0] vr);
    ent_t   e;
    pulse_t q;
    int     n;
    e.v = vr; e.val = vl; e.typ = t;
    n = m_stack.size();
    if (m_busy) begin
      if (p || po) m_error = 1'b1;
      q = m_pulses.pop_front();
      if (!q.is_flip) begin
        void'(m_stack.pop_back());
        if (m_pulses.size() == 0) begin
          m_busy  = 1'b0;
          m_unsat = 1'b1;
        end
      end else begin
        m_stack[n-1].val = q.val;
        m_stack[n-1].typ = TYPE_FORCED;
        m_busy = 1'b0;
      end
    end else if (bt) begin
      if (n == 0) m_unsat = 1'b1;
      else begin
        for (int i = n - 1; i >= 0; i--) begin
          if (m_stack[i].typ == TYPE_FORCED) begin
            m_pulses.push_back('{1'b0, m_stack[i].v, 1'b0});
          end else begin
            m_pulses.push_back('{1'b1, m_stack[i].v, ~m_stack[i].val});
            break;
          end
        end
        m_busy = 1'b1;
      end
    end else if (p && po) begin
      if (n > 0) void'(m_stack.pop_back());
      m_stack.push_back(e);
    end else if (p) begin
      if (n == DEPTH) m_error = 1'b1;
      else m_stack.push_back(e);
    end else if (po) begin
      if (n == 0) m_error = 1'b1;
      else void'(m_stack.pop_back());
    end
  endtask

  task automatic step(input logic p, input logic po, input logic bt,
                      input logic t, input logic vl, input logic [VB-1:0] vr);
    @(negedge clock);
    check_outputs("cyc");
    bus.push = p; bus.pop = po; bus.backtrack = bt;
    bus.type_in = t; bus.val_in = vl; bus.var_in = vr;
    @(posedge clock);
    model_update(p, po, bt, t, vl, vr);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic push_e(input logic t, input logic vl, input logic [VB-1:0] vr);
    step(1'b1, 1'b0, 1'b0, t, vl, vr);
  endtask

  task automatic do_reset();
    bus.push = 1'b0; bus.pop = 1'b0; bus.backtrack = 1'b0;
    bus.type_in = 1'b0; bus.val_in = 1'b0; bus.var_in = '0;
    #1 reset_n = 1'b0;
    m_stack.delete();
    m_pulses.delete();
    m_busy = 1'b0; m_unsat = 1'b0; m_error = 1'b0;
    #1 check_outputs("rst");
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    // Pop while empty.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(1);

    // Single forced push then pop.
    do_reset();
    push_e(TYPE_FORCED, 1'b1, 8'd69);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(1);

    // Unwind two forced entries onto a decision.
    do_reset();
    push_e(TYPE_DECIDE, 1'b0, 8'd12);
    push_e(TYPE_FORCED, 1'b1, 8'd13);
    push_e(TYPE_FORCED, 1'b0, 8'd14);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(4);

    // No decision left: unsat, with a push attempted mid-unwind.
    do_reset();
    push_e(TYPE_FORCED, 1'b1, 8'd5);
    push_e(TYPE_FORCED, 1'b0, 8'd6);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    push_e(TYPE_DECIDE, 1'b1, 8'd99);
    idle(3);

    // Overflow, then push+pop on a full stack.
    do_reset();
    push_e(TYPE_DECIDE, 1'b1, 8'd1);
    push_e(TYPE_FORCED, 1'b0, 8'd2);
    push_e(TYPE_DECIDE, 1'b0, 8'd3);
    push_e(TYPE_FORCED, 1'b1, 8'd4);
    push_e(TYPE_FORCED, 1'b1, 8'd5);
    step(1'b1, 1'b1, 1'b0, TYPE_DECIDE, 1'b1, 8'd77);
    idle(1);

    // Reset in the middle of an unwind.
    do_reset();
    push_e(TYPE_DECIDE, 1'b1, 8'd21);
    push_e(TYPE_FORCED, 1'b0, 8'd22);
    push_e(TYPE_FORCED, 1'b1, 8'd23);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(1);
    do_reset();
    idle(1);

    // Randomized episodes.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      for (int c = 0; c < 80; c++) begin
        logic          p, po, bt, t, vl;
        logic [VB-1:0] vr;
        bt = ($urandom_range(0, 9) == 0);
        p  = ($urandom_range(0, 2) != 0);
        po = ($urandom_range(0, 2) == 0);
        t  = $urandom_range(0, 1) != 0;
        vl = $urandom_range(0, 1) != 0;
        vr = VB'($urandom_range(0, 255));
        step(p, po, bt, t, vl, vr);
      end
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trail_stack.md
# trail_stack

Parametrised assignment-trail stack for the DPLL solver core. Each entry records a variable, its assigned value and whether the assignment was a decision or a forced (implied) assignment. It supports plain push/pop and a hardware backtrack sequencer. The sequencer unwinds forced entries to the most recent decision, flips that decision in place, and reports unsatisfiability when no decision remains. It sits between the decision/BCP units and the variable-assignment table.

## Interface
Parameters:
- DEPTH, 16, number of entries (≥2)
- VAR_BITS, `MAX_VARS_BITS, variable index width
- CNT_BITS, $clog2(DEPTH+1), width of count/level

Ports:
- clock  in  1  rising-edge clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- push  in  1  push {var_in,val_in,type_in}
- pop  in  1  discard top entry
- backtrack  in  1  start backtrack sequence
- type_in  in  1  0 = decision, 1 = forced
- val_in  in  1  assigned value
- var_in  in  VAR_BITS  variable index
- var_out / val_out / type_out  out  VAR_BITS/1/1  top entry; all 0 when empty
- unassign_valid  out  1  forced entry popped by backtrack this cycle
- unassign_var  out  VAR_BITS  variable to unassign
- flip_valid  out  1  decision flipped this cycle
- flip_var / flip_val  out  VAR_BITS/1  flipped variable, new value
- busy  out  1  backtrack in progress
- unsat  out  1  sticky: backtrack found no decision
- error  out  1  sticky: illegal push/pop
- count  out  CNT_BITS  occupied entries
- level  out  CNT_BITS  decision entries on stack (decision level)
- empty / full  out  1  count==0 / count==DEPTH

## Operation
- States: IDLE, UNWIND.
- IDLE, push only:
  - Write at index count; count+1.
  - level+1 if type_in==0.
  - When full: entry dropped, error set.
- IDLE, pop only:
  - count−1; level−1 if the top is a decision.
  - When empty: no change, error set.
- IDLE, push and pop together:
  - Top replaced by the new entry; count unchanged; level adjusted for the removed and added types.
  - When empty: acts as push only, no error.
- IDLE, backtrack (has priority over push/pop, which are ignored that cycle with no error):
  - Non-empty: go to UNWIND.
  - Empty: set unsat, stay IDLE.
- UNWIND, each cycle, on the top entry:
  - Forced: unassign_valid=1, unassign_var=top var; pop at the edge.
  - Forced and it was the last entry (count==1): after the pop, set unsat and return to IDLE.
  - Decision: flip_valid=1, flip_var=top var, flip_val=~top val; at the edge the top is rewritten as {var, ~val, forced}; count unchanged; level−1; return to IDLE.
- busy==1 exactly while in UNWIND.
  - push or pop asserted while busy: ignored, error set.
  - backtrack while busy: ignored, no error.
- unassign_* and flip_* are combinational from state and top entry. They are zero outside UNWIND.
- unsat and error clear only on reset.

## Timing
- Reset (async assert, sync deassert by the system):
  - state IDLE; count=0, level=0.
  - empty=1, full=0, busy=0, unsat=0, error=0.
  - All data and strobe outputs 0. Storage is not cleared.
- Push/pop take effect at the rising edge. The top outputs, count, level, empty and full update in the next cycle.
- Backtrack with n forced entries above the nearest decision:
  - busy is high for n+1 cycles, starting the cycle after backtrack is sampled.
  - n unassign pulses occur in stack order (top first), then one flip pulse.
  - IDLE again on cycle n+2.
- No decision present: n unassign pulses; unsat rises the cycle after the last pulse, with empty=1.
- Reset asserted mid-UNWIND aborts immediately to the reset state.

## Structure
- Package trail_pkg: TYPE_DECIDE=1'b0, TYPE_FORCED=1'b1, and the state enum trail_state_t {IDLE, UNWIND}.
- Sub-module trail_mem:
  - DEPTH × (VAR_BITS+2) register array.
  - One write port (index, data, enable); one combinational read at count−1.
  - trail_stack owns the pointer, level counter, FSM and flags.

## Test plan
(All with DEPTH=4.)
1. Reset, then pop while empty → error=1, count=0, empty=1, all outputs 0.
2. Push (69,1,forced), then pop → top=69/1/1 with count=1, then empty=1; level stays 0.
3. Push D(12,0), F(13,1), F(14,0), then backtrack:
   - unassign 14, then unassign 13, then flip_valid with flip_var=12, flip_val=1.
   - busy held 3 cycles; afterwards top=12/1/forced, count=1, level=0.
4. Push F(5), F(6), then backtrack → unassign 6, unassign 5, then unsat=1, empty=1. A push during busy sets error.
5. Push 4 entries, then a 5th → full=1, error=1, top unchanged. Push and pop together on full → top replaced, count=4, no further error.
6. Assert reset_n low midway through a 3-entry unwind → all outputs 0 immediately, count=0, unsat=0.
